// File: rtl/div_iter_core_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and the cleared-result value.
// Imported by div_iter_core and its sub-module.
package div_iter_core_pkg;

    localparam int unsigned DIV_DATA_W = 32;
    localparam int unsigned DIV_MAX_W  = 64;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Wide enough for any DATA_W up to DIV_MAX_W; users slice the low 2*DATA_W bits.
    localparam logic [2*DIV_MAX_W-1:0] DIV_RESULT_ZERO = {(2*DIV_MAX_W){1'b0}};

endpackage

// File: rtl/div_iter_core_if.sv
// EX-stage divide handshake between the divide controller (master) and the divider (slave).
// dbz_o exists only when DIV_DBZ_FLAG_EN is defined.
interface div_iter_core_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;
`ifdef DIV_DBZ_FLAG_EN
    logic                  dbz_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, dbz_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, dbz_o
    );
`else
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
`endif

endinterface

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: trial-subtract the divisor from the partial remainder
// and shift the work register left, inserting the quotient bit.
module div_restore_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] work_in,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W:0]   work_out
);

    logic [DATA_W:0] diff_s;

    // Trial subtraction in DATA_W+1 bits; the top bit is the borrow.
    always_comb begin
        diff_s = {1'b0, work_in[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
        if (diff_s[DATA_W]) begin
            work_out = {work_in, 1'b0};
        end else begin
            work_out = {diff_s[DATA_W-1:0], work_in[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter_core.sv
// Iterative radix-2 restoring divider (DIV/DIVU) answering the EX-stage divide handshake.
// Optional feature macro: DIV_DBZ_FLAG_EN adds the dbz_o divide-by-zero flag.
module div_iter_core
    import div_iter_core_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    div_iter_core_if.slave bus
);

    localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1'b1);
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic is_signed);
        logic [DATA_W-1:0] m;
        if (is_signed && v[DATA_W-1]) begin
            m = twos_neg(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    div_state_e            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [2*DATA_W:0]     work_r;
    logic [DATA_W-1:0]     divisor_r;
    logic                  signed_r;
    logic                  op1_neg_r;
    logic                  op2_neg_r;
    logic [2*DATA_W-1:0]   result_r;
    logic                  ready_r;
    logic                  busy_r;
`ifdef DIV_DBZ_FLAG_EN
    logic                  zero_r;
    logic                  dbz_r;
`endif

    logic [2*DATA_W:0]     work_next_s;
    logic [DATA_W-1:0]     quot_fix_s;
    logic [DATA_W-1:0]     rem_fix_s;

    div_restore_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .work_in  (work_r[2*DATA_W-1:0]),
        .divisor  (divisor_r),
        .work_out (work_next_s)
    );

    // Sign correction of the final step's quotient and remainder (remainder follows the dividend).
    always_comb begin
        quot_fix_s = work_next_s[DATA_W-1:0];
        rem_fix_s  = work_next_s[2*DATA_W:DATA_W+1];
        if (signed_r && (op1_neg_r ^ op2_neg_r)) begin
            quot_fix_s = twos_neg(work_next_s[DATA_W-1:0]);
        end else begin
            quot_fix_s = work_next_s[DATA_W-1:0];
        end
        if (signed_r && op1_neg_r) begin
            rem_fix_s = twos_neg(work_next_s[2*DATA_W:DATA_W+1]);
        end else begin
            rem_fix_s = work_next_s[2*DATA_W:DATA_W+1];
        end
    end

    // Divider FSM with iteration counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= DIV_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            work_r    <= {(2*DATA_W+1){1'b0}};
            divisor_r <= {DATA_W{1'b0}};
            signed_r  <= 1'b0;
            op1_neg_r <= 1'b0;
            op2_neg_r <= 1'b0;
            result_r  <= DIV_RESULT_ZERO[2*DATA_W-1:0];
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
            zero_r    <= 1'b0;
            dbz_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        busy_r <= 1'b1;
                        if (bus.opdata2_i == {DATA_W{1'b0}}) begin
                            state_r <= DIV_BYZERO;
`ifdef DIV_DBZ_FLAG_EN
                            zero_r  <= 1'b1;
`endif
                        end else begin
                            state_r   <= DIV_ON;
                            signed_r  <= bus.signed_div_i;
                            op1_neg_r <= bus.opdata1_i[DATA_W-1];
                            op2_neg_r <= bus.opdata2_i[DATA_W-1];
                            divisor_r <= magnitude(bus.opdata2_i, bus.signed_div_i);
                            work_r    <= {{DATA_W{1'b0}}, magnitude(bus.opdata1_i, bus.signed_div_i), 1'b0};
                            cnt_r     <= {CNT_W{1'b0}};
                        end
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_BYZERO: begin
                    busy_r <= 1'b0;
                    if (bus.annul_i) begin
                        state_r <= DIV_IDLE;
`ifdef DIV_DBZ_FLAG_EN
                        zero_r  <= 1'b0;
`endif
                    end else begin
                        state_r  <= DIV_END;
                        result_r <= DIV_RESULT_ZERO[2*DATA_W-1:0];
                    end
                end
                DIV_ON: begin
                    if (bus.annul_i) begin
                        state_r <= DIV_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        work_r <= work_next_s;
                        cnt_r  <= cnt_r + CNT_W'(1'b1);
                        if (cnt_r == CNT_LAST) begin
                            state_r  <= DIV_END;
                            busy_r   <= 1'b0;
                            result_r <= {rem_fix_s, quot_fix_s};
                        end else begin
                            state_r <= DIV_ON;
                        end
                    end
                end
                DIV_END: begin
                    if (!bus.start_i) begin
                        state_r  <= DIV_IDLE;
                        ready_r  <= 1'b0;
                        result_r <= DIV_RESULT_ZERO[2*DATA_W-1:0];
`ifdef DIV_DBZ_FLAG_EN
                        zero_r   <= 1'b0;
                        dbz_r    <= 1'b0;
`endif
                    end else begin
                        state_r <= DIV_END;
                        ready_r <= 1'b1;
`ifdef DIV_DBZ_FLAG_EN
                        dbz_r   <= zero_r;
`endif
                    end
                end
                default: begin
                    state_r  <= DIV_IDLE;
                    ready_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    result_r <= DIV_RESULT_ZERO[2*DATA_W-1:0];
                end
            endcase
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;
    assign bus.busy_o   = busy_r;
`ifdef DIV_DBZ_FLAG_EN
    assign bus.dbz_o    = dbz_r;
`endif

endmodule
